// File: rtl/parts_pkg.sv
// Shared types for blocks that use the push/pop stack discipline.
package parts_pkg;

    typedef enum logic [1:0] {
        STK_NONE,
        STK_PUSH,
        STK_POP,
        STK_REPL
    } stack_op_t;

    // Both strobes together replace the top entry instead of cancelling out.
    function automatic stack_op_t decode_stack_op(input logic push, input logic pop);
        stack_op_t op;
        case ({push, pop})
            2'b10:   op = STK_PUSH;
            2'b01:   op = STK_POP;
            2'b11:   op = STK_REPL;
            default: op = STK_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Stack pointer, entry count and error flag for a descending LIFO.
// The stack pointer always names the next free slot, so the top entry lives at sp+1.
// Storage is not kept here: this block only tells the array which slot to write.
module stack_ctrl
    import parts_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter bit WRAP  = 1'b1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear_err,
    output logic [AW-1:0] sp,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          err,
    output logic          stk_we,
    output logic [AW-1:0] stk_idx
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    stack_op_t     op;
    logic [AW-1:0] sp_q, sp_d, sp_inc, sp_dec;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          do_push;
    logic          ovf, unf;

    assign op      = decode_stack_op(push, pop);
    assign sp_inc  = sp_q + 1'b1;
    assign sp_dec  = sp_q - 1'b1;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    // A replace on an empty stack has no top to overwrite, so it becomes a push.
    assign do_push = (op == STK_PUSH) || ((op == STK_REPL) && empty);

    // Next pointer/count, array write request, and overflow/underflow detection.
    always_comb begin
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        stk_we  = 1'b0;
        stk_idx = sp_q;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (do_push) begin
            if (full) begin
                ovf = 1'b1;
                if (WRAP) begin
                    // Oldest entry gets overwritten; count already at its ceiling.
                    stk_we = 1'b1;
                    sp_d   = sp_dec;
                end
            end else begin
                stk_we = 1'b1;
                sp_d   = sp_dec;
                cnt_d  = cnt_q + 1'b1;
            end
        end else if (op == STK_POP) begin
            if (empty) begin
                unf = 1'b1;
                if (WRAP) begin
                    sp_d = sp_inc;
                end
            end else begin
                sp_d  = sp_inc;
                cnt_d = cnt_q - 1'b1;
            end
        end else if (op == STK_REPL) begin
            stk_we  = 1'b1;
            stk_idx = sp_inc;
        end
        // A fresh error outranks a clear request in the same cycle.
        if (ovf || unf) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Stack state registers; reset leaves an empty stack with sp at the top slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= AW'(DEPTH - 1);
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign sp    = sp_q;
    assign count = cnt_q;
    assign err   = err_q;

endmodule

// File: rtl/regstack.sv
// Flop-based register file with two combinational read ports, one indexed write
// port, and a LIFO stack sharing the same array. Stack writes win over the
// indexed port when both hit the same entry.
module regstack
    import parts_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter bit BYPASS = 1'b1,
    parameter bit WRAP   = 1'b1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [AW-1:0]    sp,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             err,
    input  logic             clear_err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             stk_we;
    logic [AW-1:0]    stk_idx;
    logic [AW-1:0]    top_idx;

    stack_ctrl #(
        .DEPTH (DEPTH),
        .WRAP  (WRAP)
    ) u_stack_ctrl (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear_err (clear_err),
        .sp        (sp),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .err       (err),
        .stk_we    (stk_we),
        .stk_idx   (stk_idx)
    );

    // Array update: stack write takes priority over the indexed write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (stk_we && (stk_idx == AW'(i))) begin
                    mem[i] <= push_data;
                end else if (we && (waddr == AW'(i))) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // Read ports, with optional same-cycle forwarding of the indexed write data.
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (BYPASS && we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        if (BYPASS && we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

    // Top of stack sits one above the free slot, wrapping at the array end.
    assign top_idx  = sp + 1'b1;
    assign top_data = mem[top_idx];

endmodule
